// File: rtl/npu_param_loader_if.sv
// Command and byte-stream handshake bundle between the host side and the
// NPU parameter loader. The host is the master; the loader is the slave.
interface npu_param_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_target;
  logic [15:0] cmd_base;
  logic [15:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        abort;

  modport master (
    output cmd_valid, cmd_target, cmd_base, cmd_len, in_valid, in_data, abort,
    input  cmd_ready, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_base, cmd_len, in_valid, in_data, abort,
    output cmd_ready, in_ready
  );
endinterface

// File: rtl/npu_param_loader.sv
// Write-side loader for the NPU memory block. Takes a load command (target,
// base byte address, byte count) followed by a byte stream, and turns each
// accepted byte into one registered write on the selected RAM's write port.
module npu_param_loader #(
  parameter int IMG_BYTES   = 4096,
  parameter int PARAM_BYTES = 32768
) (
  input  logic        clk,
  input  logic        reset,
  npu_param_loader_if.slave bus,
  output logic [9:0]  image_ram_addr_a,
  output logic [7:0]  data_image0,
  output logic [7:0]  data_image1,
  output logic [7:0]  data_image2,
  output logic [7:0]  data_image3,
  output logic        we_image0,
  output logic        we_image1,
  output logic        we_image2,
  output logic        we_image3,
  output logic [14:0] conv_ram_addr_a,
  output logic [14:0] dense_ram_addr_a,
  output logic [14:0] denseb_ram_addr_a,
  output logic [7:0]  data_conv,
  output logic [7:0]  data_dense,
  output logic [7:0]  data_denseb,
  output logic        we_conv,
  output logic        we_dense,
  output logic        we_denseb,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2} state_t;

  localparam logic [1:0] TGT_IMAGE = 2'd0;
  localparam logic [1:0] TGT_CONV  = 2'd1;
  localparam logic [1:0] TGT_DENSE = 2'd2;

  state_t      state_reg;
  logic [1:0]  target_reg;
  logic [14:0] ptr_reg;        // base + len never exceeds 32768, so 15 bits suffice
  logic [15:0] remaining_reg;
  logic [3:0]  we_image_reg;
  logic [7:0]  data_image_reg [4];

  logic [16:0] cmd_end;
  logic [16:0] capacity;
  logic        cmd_bad;
  logic        in_ready_int;
  logic        accept;

  // Range check on the incoming command; only used in IDLE and only
  // affects registered state, so there is no path from cmd_* to RAM ports.
  assign cmd_end  = {1'b0, bus.cmd_base} + {1'b0, bus.cmd_len};
  assign capacity = (bus.cmd_target == TGT_IMAGE) ? 17'(IMG_BYTES) : 17'(PARAM_BYTES);
  assign cmd_bad  = (bus.cmd_len == 16'd0) || (cmd_end > capacity);

  // Abort masks in_ready so the byte presented with abort is never taken.
  assign in_ready_int  = (state_reg == LOAD) && !bus.abort;
  assign accept        = in_ready_int && bus.in_valid;
  assign bus.in_ready  = in_ready_int;
  assign bus.cmd_ready = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);

  assign we_image0   = we_image_reg[0];
  assign we_image1   = we_image_reg[1];
  assign we_image2   = we_image_reg[2];
  assign we_image3   = we_image_reg[3];
  assign data_image0 = data_image_reg[0];
  assign data_image1 = data_image_reg[1];
  assign data_image2 = data_image_reg[2];
  assign data_image3 = data_image_reg[3];

  // Loader FSM: command intake, per-byte write-port generation, completion and abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      target_reg        <= TGT_IMAGE;
      ptr_reg           <= '0;
      remaining_reg     <= '0;
      we_image_reg      <= '0;
      for (int i = 0; i < 4; i++) data_image_reg[i] <= '0;
      image_ram_addr_a  <= '0;
      conv_ram_addr_a   <= '0;
      dense_ram_addr_a  <= '0;
      denseb_ram_addr_a <= '0;
      data_conv         <= '0;
      data_dense        <= '0;
      data_denseb       <= '0;
      we_conv           <= 1'b0;
      we_dense          <= 1'b0;
      we_denseb         <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      // Write enables and status pulses last exactly one cycle.
      we_image_reg <= '0;
      we_conv      <= 1'b0;
      we_dense     <= 1'b0;
      we_denseb    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              target_reg    <= bus.cmd_target;
              ptr_reg       <= bus.cmd_base[14:0];
              remaining_reg <= bus.cmd_len;
              state_reg     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_reg <= IDLE;
            err       <= 1'b1;
          end else if (accept) begin
            case (target_reg)
              TGT_IMAGE: begin
                // Byte address interleaves across banks: low two bits pick the bank.
                we_image_reg[ptr_reg[1:0]]   <= 1'b1;
                data_image_reg[ptr_reg[1:0]] <= bus.in_data;
                image_ram_addr_a             <= ptr_reg[11:2];
              end
              TGT_CONV: begin
                we_conv         <= 1'b1;
                data_conv       <= bus.in_data;
                conv_ram_addr_a <= ptr_reg;
              end
              TGT_DENSE: begin
                we_dense         <= 1'b1;
                data_dense       <= bus.in_data;
                dense_ram_addr_a <= ptr_reg;
              end
              default: begin
                we_denseb         <= 1'b1;
                data_denseb       <= bus.in_data;
                denseb_ram_addr_a <= ptr_reg;
              end
            endcase
            ptr_reg       <= ptr_reg + 15'd1;
            remaining_reg <= remaining_reg - 16'd1;
            if (remaining_reg == 16'd1) begin
              state_reg <= FIN;
              done      <= 1'b1;
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_param_loader.sv
// Directed bench for npu_param_loader: a transaction-level model predicts
// every RAM write-port and status output, checked each cycle, plus
// hand-computed literal checks on key cycles.
module tb_npu_param_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  npu_param_loader_if bus ();

  logic [9:0]  image_ram_addr_a;
  logic [7:0]  data_image0, data_image1, data_image2, data_image3;
  logic        we_image0, we_image1, we_image2, we_image3;
  logic [14:0] conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a;
  logic [7:0]  data_conv, data_dense, data_denseb;
  logic        we_conv, we_dense, we_denseb;
  logic        busy, done, err;

  npu_param_loader #(.IMG_BYTES(4096), .PARAM_BYTES(32768)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .image_ram_addr_a  (image_ram_addr_a),
    .data_image0       (data_image0),
    .data_image1       (data_image1),
    .data_image2       (data_image2),
    .data_image3       (data_image3),
    .we_image0         (we_image0),
    .we_image1         (we_image1),
    .we_image2         (we_image2),
    .we_image3         (we_image3),
    .conv_ram_addr_a   (conv_ram_addr_a),
    .dense_ram_addr_a  (dense_ram_addr_a),
    .denseb_ram_addr_a (denseb_ram_addr_a),
    .data_conv         (data_conv),
    .data_dense        (data_dense),
    .data_denseb       (data_denseb),
    .we_conv           (we_conv),
    .we_dense          (we_dense),
    .we_denseb         (we_denseb),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  int denseb_writes = 0;

  // Transaction-level model: an active load is (target, next byte address,
  // bytes left); "finishing" is the one cycle after the last byte.
  int          m_phase = 0;   // 0 idle, 1 loading, 2 finishing
  int          m_tgt = 0;
  int          m_addr = 0;
  int          m_left = 0;
  int          m_cap;
  logic [9:0]  e_img_addr;
  logic [7:0]  e_img_data [4];
  logic [3:0]  e_img_we;
  logic [14:0] e_p_addr [3];
  logic [7:0]  e_p_data [3];
  logic [2:0]  e_p_we;        // [0] conv, [1] dense, [2] denseb
  logic        e_done, e_err;

  // Model update on every rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    e_img_we = '0;
    e_p_we   = '0;
    e_done   = 1'b0;
    e_err    = 1'b0;
    if (!reset) begin
      m_phase = 0; m_addr = 0; m_left = 0;
      e_img_addr = '0;
      for (int i = 0; i < 4; i++) e_img_data[i] = '0;
      for (int i = 0; i < 3; i++) begin e_p_addr[i] = '0; e_p_data[i] = '0; end
    end else if (m_phase == 0) begin
      if (bus.cmd_valid) begin
        m_cap = (bus.cmd_target == 2'd0) ? 4096 : 32768;
        if (bus.cmd_len == 16'd0 || int'(bus.cmd_base) + int'(bus.cmd_len) > m_cap) begin
          e_err = 1'b1;
        end else begin
          m_phase = 1; m_tgt = int'(bus.cmd_target);
          m_addr = int'(bus.cmd_base); m_left = int'(bus.cmd_len);
        end
      end
    end else if (m_phase == 1) begin
      if (bus.abort) begin
        m_phase = 0; e_err = 1'b1;
      end else if (bus.in_valid) begin
        if (m_tgt == 0) begin
          e_img_we[m_addr % 4]   = 1'b1;
          e_img_data[m_addr % 4] = bus.in_data;
          e_img_addr             = 10'(m_addr / 4);
        end else begin
          e_p_we[m_tgt - 1]   = 1'b1;
          e_p_data[m_tgt - 1] = bus.in_data;
          e_p_addr[m_tgt - 1] = 15'(m_addr);
        end
        m_addr = m_addr + 1;
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = 2; e_done = 1'b1; end
      end
    end else begin
      m_phase = 0;
    end
  end

  logic [122:0] act_vec, exp_vec;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (we_denseb === 1'b1) denseb_writes = denseb_writes + 1;
    if (chk_en) begin
      act_vec = {image_ram_addr_a, data_image0, data_image1, data_image2, data_image3,
                 we_image3, we_image2, we_image1, we_image0,
                 conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a,
                 data_conv, data_dense, data_denseb, we_conv, we_dense, we_denseb,
                 busy, done, err, bus.cmd_ready, bus.in_ready};
      exp_vec = {e_img_addr, e_img_data[0], e_img_data[1], e_img_data[2], e_img_data[3],
                 e_img_we[3], e_img_we[2], e_img_we[1], e_img_we[0],
                 e_p_addr[0], e_p_addr[1], e_p_addr[2],
                 e_p_data[0], e_p_data[1], e_p_data[2], e_p_we[0], e_p_we[1], e_p_we[2],
                 (m_phase != 0), e_done, e_err, (m_phase == 0),
                 ((m_phase == 1) && !bus.abort)};
      n_cmp = n_cmp + 1;
      if (act_vec !== exp_vec) begin
        n_fail = n_fail + 1;
        $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_vec, exp_vec);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] tgt, input logic [15:0] base, input logic [15:0] len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    bus.cmd_base   = base;
    bus.cmd_len    = len;
    tick();
    bus.cmd_valid  = 1'b0;
    $display("cmd target=%0d base=%h len=%0d", tgt, base, len);
  endtask

  task automatic send(input logic vld, input logic [7:0] d);
    bus.in_valid = vld;
    bus.in_data  = d;
    tick();
    $display("byte valid=%0b data=%h", vld, d);
  endtask

  int snap;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_target = 2'd0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.abort = 1'b0;

    // Reset
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // Image load, base 0, 8 bytes without gaps
    cmd(2'd0, 16'd0, 16'd8);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 8'(8'h10 + i));
      if (i == 0) begin
        check("img_first_we0", 32'(we_image0), 32'd1);
        check("img_first_data", 32'(data_image0), 32'h10);
        check("img_first_addr", 32'(image_ram_addr_a), 32'd0);
      end
      if (i == 4) begin
        check("img_fifth_data", 32'(data_image0), 32'h14);
        check("img_fifth_addr", 32'(image_ram_addr_a), 32'd1);
      end
    end
    check("img_last_done", 32'(done), 32'd1);
    check("img_last_we3", 32'(we_image3), 32'd1);
    check("img_last_data", 32'(data_image3), 32'h17);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);

    // Conv load at the top of the RAM with a gap between bytes
    cmd(2'd1, 16'h7FFE, 16'd2);
    send(1'b1, 8'hA1);
    send(1'b0, 8'h00);
    send(1'b1, 8'hA2);
    check("conv_done", 32'(done), 32'd1);
    check("conv_addr", 32'(conv_ram_addr_a), 32'h7FFF);
    check("conv_data", 32'(data_conv), 32'hA2);
    send(1'b0, 8'h00);
    check("conv_cmd_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Rejected commands: dense overflow, denseb zero length
    cmd(2'd2, 16'h7FFF, 16'd2);
    check("dense_ovf_err", 32'(err), 32'd1);
    check("dense_ovf_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    cmd(2'd3, 16'h0010, 16'd0);
    check("denseb_len0_err", 32'(err), 32'd1);
    send(1'b0, 8'h00);

    // Denseb load of 5 aborted on the third byte
    snap = denseb_writes;
    cmd(2'd3, 16'h0100, 16'd5);
    send(1'b1, 8'h31);
    send(1'b1, 8'h32);
    bus.abort = 1'b1;
    send(1'b1, 8'h33);
    check("abort_err", 32'(err), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    bus.abort = 1'b0;
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_write_count", 32'(denseb_writes - snap), 32'd2);

    // Reset in the middle of a 16-byte image load
    cmd(2'd0, 16'd0, 16'd16);
    for (int i = 0; i < 5; i++) send(1'b1, 8'(8'h40 + i));
    reset = 1'b0;
    send(1'b1, 8'h45);
    check("rst_we_image", 32'({we_image3, we_image2, we_image1, we_image0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    reset = 1'b1;
    send(1'b0, 8'h00);
    cmd(2'd1, 16'd3, 16'd1);
    send(1'b1, 8'h5C);
    check("post_rst_we_conv", 32'(we_conv), 32'd1);
    check("post_rst_conv_addr", 32'(conv_ram_addr_a), 32'd3);
    check("post_rst_conv_data", 32'(data_conv), 32'h5C);
    send(1'b0, 8'h00);

    // Image boundary: last byte accepted, one past rejected
    cmd(2'd0, 16'd4095, 16'd1);
    send(1'b1, 8'hEE);
    check("img_edge_we3", 32'(we_image3), 32'd1);
    check("img_edge_addr", 32'(image_ram_addr_a), 32'd1023);
    send(1'b0, 8'h00);
    cmd(2'd0, 16'd4095, 16'd2);
    check("img_edge_ovf_err", 32'(err), 32'd1);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
